afifo_wr_ctrl: RTL and testbench

//  Write-domain controller for the async FIFO, parametrised successor of the fixed 1024-deep write logic.

---
 rtl/afifo_wr_ctrl.sv | 78 +++++++
 tb/tb_afifo_wr_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_wr_ctrl.sv
// Write-domain half of the async FIFO: write pointers, RAM write strobe/address, read-pointer
// synchroniser, and registered full / almost-full / level / sticky overflow status.
module afifo_wr_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 1020
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              wen,
  input  logic              clr_ovf,
  input  logic [ADDR_W:0]   rptr_g_async,
  output logic              wr_en_mem,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_g,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              woverflow
);

  localparam logic [ADDR_W:0] THRESH = (ADDR_W+1)'(AFULL_THRESH);

  logic [ADDR_W:0]                   wbin_q, wbin_d;
  logic [ADDR_W:0]                   wptr_g_q, wptr_g_d;
  logic [SYNC_STAGES-1:0][ADDR_W:0]  sync_q;
  logic [ADDR_W:0]                   rq_g, rbin;
  logic [ADDR_W:0]                   wlevel_q, wlevel_d;
  logic                              wfull_q, wfull_d;
  logic                              afull_q, afull_d;
  logic                              ovf_q, ovf_d;

  assign wr_en_mem = wen & ~wfull_q;
  assign wbin_d    = wbin_q + {{ADDR_W{1'b0}}, wr_en_mem};
  assign wptr_g_d  = wbin_d ^ (wbin_d >> 1);

  assign rq_g = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) rbin[i] = ^(rq_g >> i);
  end

  // Full when the next write pointer is exactly one lap ahead of the synchronised read pointer.
  assign wfull_d  = (wptr_g_d == {~rq_g[ADDR_W:ADDR_W-1], rq_g[ADDR_W-2:0]});
  assign wlevel_d = wbin_d - rbin;
  assign afull_d  = (wlevel_d >= THRESH);
  assign ovf_d    = (wen & wfull_q) | (ovf_q & ~clr_ovf);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_g_q <= '0;
      sync_q   <= '0;
      wfull_q  <= 1'b0;
      afull_q  <= 1'b0;
      wlevel_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_g_q <= wptr_g_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rptr_g_async};
      wfull_q  <= wfull_d;
      afull_q  <= afull_d;
      wlevel_q <= wlevel_d;
      ovf_q    <= ovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_W-1:0];
  assign wptr_g       = wptr_g_q;
  assign wfull        = wfull_q;
  assign walmost_full = afull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = ovf_q;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Drives a 1024-deep and a 4-deep write controller side by side against a count-based model
// (accepted writes minus read count delayed by the synchroniser latency).
module tb_afifo_wr_ctrl;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic        wrst_n;
  logic        wen [2];
  logic        clr [2];
  logic [10:0] rg0;
  logic [2:0]  rg1;

  logic        we0, we1, f0, f1, af0, af1, ov0, ov1;
  logic [9:0]  wa0;
  logic [1:0]  wa1;
  logic [10:0] gp0, lv0;
  logic [2:0]  gp1, lv1;

  afifo_wr_ctrl #(.ADDR_W(10), .SYNC_STAGES(2), .AFULL_THRESH(1020)) dut0 (
    .wclk(wclk), .wrst_n(wrst_n), .wen(wen[0]), .clr_ovf(clr[0]), .rptr_g_async(rg0),
    .wr_en_mem(we0), .waddr(wa0), .wptr_g(gp0), .wfull(f0), .walmost_full(af0),
    .wlevel(lv0), .woverflow(ov0));

  afifo_wr_ctrl #(.ADDR_W(2), .SYNC_STAGES(3), .AFULL_THRESH(3)) dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .wen(wen[1]), .clr_ovf(clr[1]), .rptr_g_async(rg1),
    .wr_en_mem(we1), .waddr(wa1), .wptr_g(gp1), .wfull(f1), .walmost_full(af1),
    .wlevel(lv1), .woverflow(ov1));

  logic [31:0] o_we [2], o_wa [2], o_gp [2], o_f [2], o_af [2], o_lv [2], o_ov [2];
  assign o_we[0] = 32'(we0);  assign o_we[1] = 32'(we1);
  assign o_wa[0] = 32'(wa0);  assign o_wa[1] = 32'(wa1);
  assign o_gp[0] = 32'(gp0);  assign o_gp[1] = 32'(gp1);
  assign o_f[0]  = 32'(f0);   assign o_f[1]  = 32'(f1);
  assign o_af[0] = 32'(af0);  assign o_af[1] = 32'(af1);
  assign o_lv[0] = 32'(lv0);  assign o_lv[1] = 32'(lv1);
  assign o_ov[0] = 32'(ov0);  assign o_ov[1] = 32'(ov1);

  localparam int DEP [2] = '{1024, 4};
  localparam int SS  [2] = '{2, 3};
  localparam int THR [2] = '{1020, 3};
  localparam int PM  [2] = '{2048, 8};

  int checks = 0;
  int errors = 0;

  // Reference state: total accepted writes, read count driven, log of read counts per edge.
  int wr [2], rd [2], lvl [2];
  bit full [2], af [2], ovf [2];
  int rdlog [2][8];
  int n;
  logic [31:0] prev_gp [2];

  function automatic int gray(input int x);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, j, obs, exp);
    end
  endtask

  task automatic check_regs();
    for (int j = 0; j < 2; j++) begin
      chk("wptr_g", j, o_gp[j], 32'(gray(wr[j] % PM[j])));
      chk("wfull", j, o_f[j], 32'(full[j]));
      chk("walmost_full", j, o_af[j], 32'(af[j]));
      chk("wlevel", j, o_lv[j], 32'(lvl[j]));
      chk("woverflow", j, o_ov[j], 32'(ovf[j]));
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int j = 0; j < 2; j++) begin
      wr[j] = 0; rd[j] = 0; lvl[j] = 0;
      full[j] = 0; af[j] = 0; ovf[j] = 0;
      prev_gp[j] = 0;
    end
  endtask

  // Called just after a negedge with inputs set; returns at the following negedge.
  task automatic step();
    int rq;
    rg0 = 11'(gray(rd[0] % PM[0]));
    rg1 = 3'(gray(rd[1] % PM[1]));
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("wr_en_mem", j, o_we[j], 32'(wen[j] & ~full[j]));
      chk("waddr", j, o_wa[j], 32'(wr[j] % DEP[j]));
    end
    @(posedge wclk);
    n++;
    for (int j = 0; j < 2; j++) begin
      if (wen[j] && full[j]) ovf[j] = 1;
      else if (clr[j]) ovf[j] = 0;
      if (wen[j] && !full[j]) wr[j]++;
      rdlog[j][n % 8] = rd[j];
      rq = (n - SS[j] >= 1) ? rdlog[j][(n - SS[j]) % 8] : 0;
      lvl[j]  = wr[j] - rq;
      full[j] = (lvl[j] == DEP[j]);
      af[j]   = (lvl[j] >= THR[j]);
    end
    #1;
    check_regs();
    for (int j = 0; j < 2; j++) begin
      if (o_gp[j] !== prev_gp[j]) chk("gray_1bit", j, 32'($countones(o_gp[j] ^ prev_gp[j])), 32'd1);
      prev_gp[j] = o_gp[j];
    end
    @(negedge wclk);
  endtask

  task automatic rand1();
    int t;
    wen[1] = ($urandom_range(3) != 0);
    clr[1] = ($urandom_range(7) == 0);
    t = wr[1] - int'($urandom_range(3));
    if (t > rd[1]) rd[1] = t;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    model_reset();
    rg0 = '0; rg1 = '0;
    #1;
    check_regs();
    for (int j = 0; j < 2; j++) begin
      chk("rst_wr_en_mem", j, o_we[j], 32'(wen[j]));
      chk("rst_waddr", j, o_wa[j], 32'd0);
    end
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    int t;
    wrst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin wen[j] = 0; clr[j] = 0; end
    rg0 = '0; rg1 = '0;
    @(negedge wclk);
    do_reset();

    // Fill the deep FIFO back-to-back; small FIFO runs random traffic alongside.
    wen[0] = 1;
    for (int i = 0; i < 1024; i++) begin
      rand1();
      step();
      if (i == 1018) chk("afull_before_1020", 0, o_af[0], 32'd0);
      if (i == 1019) chk("afull_at_1020", 0, o_af[0], 32'd1);
      if (i == 1022) chk("full_before_1024", 0, o_f[0], 32'd0);
    end
    chk("full_at_1024", 0, o_f[0], 32'd1);
    chk("level_1024", 0, o_lv[0], 32'd1024);
    chk("gray_1024", 0, o_gp[0], 32'h600);

    // Overflow, clear, and set-beats-clear.
    step();
    chk("ovf_set", 0, o_ov[0], 32'd1);
    chk("ovf_ptr_hold", 0, o_gp[0], 32'h600);
    wen[0] = 0; clr[0] = 1;
    step();
    chk("ovf_clr", 0, o_ov[0], 32'd0);
    wen[0] = 1;
    step();
    chk("ovf_set_wins", 0, o_ov[0], 32'd1);
    wen[0] = 0;
    step();
    clr[0] = 0;

    // Read pointer jumps to 4: full clears exactly on the third edge.
    rd[0] = 4;
    step();
    chk("full_hold_e1", 0, o_f[0], 32'd1);
    step();
    chk("full_hold_e2", 0, o_f[0], 32'd1);
    step();
    chk("full_clr_e3", 0, o_f[0], 32'd0);
    chk("level_1020", 0, o_lv[0], 32'd1020);
    chk("afull_stays", 0, o_af[0], 32'd1);

    // Long stream with the reader trailing closely: pointers wrap several times.
    for (int i = 0; i < 6800; i++) begin
      wen[0] = ($urandom_range(7) != 0);
      t = wr[0] - int'($urandom_range(8));
      if (t > rd[0]) rd[0] = t;
      rand1();
      step();
    end

    // Build level 500 then reset mid-stream.
    do_reset();
    wen[0] = 1; wen[1] = 0; clr[1] = 0;
    for (int i = 0; i < 500; i++) step();
    chk("level_500", 0, o_lv[0], 32'd500);
    do_reset();
    chk("post_rst_waddr", 0, o_wa[0], 32'd0);
    wen[0] = 0;

    // Small FIFO directed: almost-full after 3, full after 4, 4-edge read latency.
    wen[1] = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) begin
        chk("s_afull_3", 1, o_af[1], 32'd1);
        chk("s_nfull_3", 1, o_f[1], 32'd0);
      end
    end
    chk("s_full_4", 1, o_f[1], 32'd1);
    wen[1] = 0;
    rd[1] = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_level_hold", 1, o_lv[1], 32'd4);
    end
    step();
    chk("s_level_e4", 1, o_lv[1], 32'd3);
    chk("s_full_clr", 1, o_f[1], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
